// File: rtl/tdc_trace_pkg.sv
// Shared definitions for the TDC trace capture buffer and its register wrapper.
package tdc_trace_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_DEPTH      = 1024;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } trace_state_e;

endpackage

// File: rtl/tdc_trace_ram.sv
// Simple dual-port trace buffer: one write port, one registered read port.
module tdc_trace_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 1024,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Only the output register is reset; the array itself stays BRAM-friendly.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/tdc_trace_capture.sv
// Trace capture of the TDC bank output: arm, trigger-start, stop/full-end, then pop-drain.
//   state   | meaning
//   IDLE    | no trace, writes and pops blocked
//   ARMED   | pointers cleared, waiting for a trigger rising edge
//   CAPTURE | one sample written per cycle until stop or full
//   DONE    | trace frozen, pops drain it in order
module tdc_trace_capture
    import tdc_trace_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = DEFAULT_DEPTH
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [DATA_WIDTH-1:0]     data_i,
    input  logic                      arm_i,
    input  logic                      trigger_i,
    input  logic                      stop_i,
    input  logic                      read_i,
    output logic [DATA_WIDTH-1:0]     rdata_o,
    output logic                      rvalid_o,
    output logic [$clog2(DEPTH):0]    count_o,
    output logic                      empty_o,
    output logic                      done_o,
    output logic [1:0]                state_o
);

    localparam int ADDR_WIDTH = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH:0] LAST_COUNT = (ADDR_WIDTH+1)'(DEPTH - 1);

    trace_state_e          state, state_next;
    logic [ADDR_WIDTH:0]   count;
    logic [ADDR_WIDTH:0]   rd_ptr;
    logic                  trig_prev;
    logic                  trig_edge;
    logic                  wr_en;
    logic                  rd_en;
    logic                  clr;

    // A trigger already high when ARMED is entered must fall and rise again.
    assign trig_edge = trigger_i && !trig_prev;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        wr_en      = 1'b0;
        rd_en      = 1'b0;
        clr        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (arm_i) begin
                    state_next = ST_ARMED;
                    clr        = 1'b1;
                end
            end
            ST_ARMED: begin
                if (arm_i) begin
                    clr = 1'b1;
                end else if (trig_edge) begin
                    state_next = ST_CAPTURE;
                    wr_en      = 1'b1;
                end
            end
            ST_CAPTURE: begin
                wr_en = 1'b1;
                if (stop_i || (count == LAST_COUNT)) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (arm_i) begin
                    state_next = ST_ARMED;
                    clr        = 1'b1;
                end else if (read_i && (rd_ptr != count)) begin
                    rd_en = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count     <= '0;
            rd_ptr    <= '0;
            trig_prev <= 1'b0;
            rvalid_o  <= 1'b0;
        end else begin
            trig_prev <= trigger_i;
            rvalid_o  <= rd_en;
            if (clr) begin
                count  <= '0;
                rd_ptr <= '0;
            end else begin
                if (wr_en) begin
                    count <= count + 1'b1;
                end
                if (rd_en) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
            end
        end
    end

    tdc_trace_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clock (clock),
        .reset (reset),
        .we    (wr_en),
        .waddr (count[ADDR_WIDTH-1:0]),
        .wdata (data_i),
        .re    (rd_en),
        .raddr (rd_ptr[ADDR_WIDTH-1:0]),
        .rdata (rdata_o)
    );

    assign count_o = count;
    assign state_o = state;
    assign done_o  = (state == ST_DONE);
    assign empty_o = (state == ST_DONE) && (rd_ptr == count);

endmodule

// File: tb/tb_tdc_trace_capture.sv
// Directed bench for tdc_trace_capture at DEPTH=16: vector table plus multi-cycle sequences.
module tb_tdc_trace_capture;

    localparam int DW    = 8;
    localparam int DEPTH = 16;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] data_i = '0;
    logic          arm_i = 1'b0;
    logic          trigger_i = 1'b0;
    logic          stop_i = 1'b0;
    logic          read_i = 1'b0;
    logic [DW-1:0] rdata_o;
    logic          rvalid_o;
    logic [4:0]    count_o;
    logic          empty_o;
    logic          done_o;
    logic [1:0]    state_o;

    int errors = 0;
    int checks = 0;

    tdc_trace_capture #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clock     (clock),
        .reset     (reset),
        .data_i    (data_i),
        .arm_i     (arm_i),
        .trigger_i (trigger_i),
        .stop_i    (stop_i),
        .read_i    (read_i),
        .rdata_o   (rdata_o),
        .rvalid_o  (rvalid_o),
        .count_o   (count_o),
        .empty_o   (empty_o),
        .done_o    (done_o),
        .state_o   (state_o)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       arm, trig, stop, rd;
        logic [7:0] data;
        logic [1:0] st;
        logic [4:0] cnt;
        logic       rv;
        logic [7:0] rdat;
        logic       emp, dn;
    } vec_t;

    vec_t vecs[18];

    function automatic vec_t mk(input logic a, t, s, r, input logic [7:0] d,
                                input logic [1:0] st, input logic [4:0] cnt,
                                input logic rv, input logic [7:0] rdat,
                                input logic emp, dn);
        vec_t v;
        v.arm = a; v.trig = t; v.stop = s; v.rd = r; v.data = d;
        v.st = st; v.cnt = cnt; v.rv = rv; v.rdat = rdat; v.emp = emp; v.dn = dn;
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_all(input string nm, input logic [1:0] st, input logic [4:0] cnt,
                           input logic rv, input logic [7:0] rdat, input logic emp, dn);
        chk({nm, ".state"},  int'(state_o),  int'(st));
        chk({nm, ".count"},  int'(count_o),  int'(cnt));
        chk({nm, ".rvalid"}, int'(rvalid_o), int'(rv));
        chk({nm, ".rdata"},  int'(rdata_o),  int'(rdat));
        chk({nm, ".empty"},  int'(empty_o),  int'(emp));
        chk({nm, ".done"},   int'(done_o),   int'(dn));
    endtask

    initial begin
        //                arm trg stp rd  data   st  cnt rv rdata emp dn
        vecs[0]  = mk(0, 0, 0, 1, 8'h00, 2'd0, 5'd0, 0, 8'h00, 0, 0); // pop in IDLE ignored
        vecs[1]  = mk(0, 1, 0, 0, 8'h00, 2'd0, 5'd0, 0, 8'h00, 0, 0); // trigger in IDLE ignored
        vecs[2]  = mk(1, 1, 0, 0, 8'h00, 2'd1, 5'd0, 0, 8'h00, 0, 0); // arm+trigger: ARMED only
        vecs[3]  = mk(0, 1, 0, 0, 8'h00, 2'd1, 5'd0, 0, 8'h00, 0, 0); // held trigger not honoured
        vecs[4]  = mk(0, 0, 0, 0, 8'h00, 2'd1, 5'd0, 0, 8'h00, 0, 0);
        vecs[5]  = mk(0, 1, 0, 0, 8'h50, 2'd2, 5'd1, 0, 8'h00, 0, 0); // new rising edge
        vecs[6]  = mk(0, 0, 0, 0, 8'h51, 2'd2, 5'd2, 0, 8'h00, 0, 0);
        vecs[7]  = mk(1, 1, 0, 0, 8'h52, 2'd2, 5'd3, 0, 8'h00, 0, 0); // arm/trigger ignored
        vecs[8]  = mk(0, 0, 0, 1, 8'h53, 2'd2, 5'd4, 0, 8'h00, 0, 0); // read ignored
        vecs[9]  = mk(0, 0, 1, 0, 8'h54, 2'd3, 5'd5, 0, 8'h00, 0, 1); // stop on 5th sample
        vecs[10] = mk(0, 0, 0, 1, 8'h99, 2'd3, 5'd5, 1, 8'h50, 0, 1);
        vecs[11] = mk(0, 0, 0, 1, 8'h99, 2'd3, 5'd5, 1, 8'h51, 0, 1);
        vecs[12] = mk(0, 0, 0, 1, 8'h99, 2'd3, 5'd5, 1, 8'h52, 0, 1);
        vecs[13] = mk(0, 0, 0, 1, 8'h99, 2'd3, 5'd5, 1, 8'h53, 0, 1);
        vecs[14] = mk(0, 0, 0, 1, 8'h99, 2'd3, 5'd5, 1, 8'h54, 1, 1);
        vecs[15] = mk(0, 0, 0, 1, 8'h99, 2'd3, 5'd5, 0, 8'h54, 1, 1); // pop when empty
        vecs[16] = mk(0, 0, 0, 0, 8'h99, 2'd3, 5'd5, 0, 8'h54, 1, 1);
        vecs[17] = mk(1, 0, 0, 1, 8'h99, 2'd1, 5'd0, 0, 8'h54, 0, 0); // arm beats read

        repeat (5) @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        chk_all("reset", 2'd0, 5'd0, 1'b0, 8'h00, 1'b0, 1'b0);

        for (int i = 0; i < 18; i++) begin
            arm_i = vecs[i].arm; trigger_i = vecs[i].trig; stop_i = vecs[i].stop;
            read_i = vecs[i].rd; data_i = vecs[i].data;
            step();
            chk_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].cnt, vecs[i].rv,
                    vecs[i].rdat, vecs[i].emp, vecs[i].dn);
        end
        arm_i = 0; trigger_i = 0; stop_i = 0; read_i = 0;

        // Full capture from ARMED: DONE exactly DEPTH cycles after the trigger.
        for (int k = 0; k < DEPTH; k++) begin
            data_i = 8'(8'hA0 + k);
            trigger_i = (k == 0);
            step();
            chk($sformatf("full.state%0d", k), int'(state_o), (k == DEPTH-1) ? 3 : 2);
            chk($sformatf("full.count%0d", k), int'(count_o), k + 1);
        end
        trigger_i = 0; data_i = 8'h00;
        chk("full.done", int'(done_o), 1);
        for (int k = 0; k < DEPTH; k++) begin
            read_i = 1;
            step();
            chk($sformatf("full.rv%0d", k), int'(rvalid_o), 1);
            chk($sformatf("full.rd%0d", k), int'(rdata_o), 8'hA0 + k);
            chk($sformatf("full.emp%0d", k), int'(empty_o), (k == DEPTH-1) ? 1 : 0);
        end
        read_i = 0;
        step();
        chk("full.rv_after", int'(rvalid_o), 0);
        chk("full.empty_after", int'(empty_o), 1);

        // Re-arm and overwrite: old trace must not leak into the new one.
        arm_i = 1; step(); arm_i = 0;
        for (int k = 0; k < 6; k++) begin
            data_i = 8'(8'h11 + k); trigger_i = (k == 0); stop_i = (k == 5);
            step();
        end
        trigger_i = 0; stop_i = 0;
        chk("ow1.count", int'(count_o), 6);
        for (int k = 0; k < 2; k++) begin
            read_i = 1; step();
            chk($sformatf("ow1.rd%0d", k), int'(rdata_o), 8'h11 + k);
        end
        read_i = 0; arm_i = 1; step(); arm_i = 0;
        chk("ow.rearm_state", int'(state_o), 1);
        chk("ow.rearm_count", int'(count_o), 0);
        for (int k = 0; k < 4; k++) begin
            data_i = 8'(8'h22 + k); trigger_i = (k == 0); stop_i = (k == 3);
            step();
        end
        trigger_i = 0; stop_i = 0;
        chk("ow2.count", int'(count_o), 4);
        chk("ow2.done", int'(done_o), 1);
        for (int k = 0; k < 5; k++) begin
            read_i = 1; step();
            chk($sformatf("ow2.rv%0d", k), int'(rvalid_o), (k < 4) ? 1 : 0);
            chk($sformatf("ow2.rd%0d", k), int'(rdata_o), (k < 4) ? 8'h22 + k : 8'h25);
        end
        read_i = 0;

        // Reset in the middle of a capture acts immediately.
        arm_i = 1; step(); arm_i = 0;
        for (int k = 0; k < 8; k++) begin
            data_i = 8'(8'hB0 + k); trigger_i = (k == 0);
            step();
        end
        trigger_i = 0;
        chk("mid.count_pre", int'(count_o), 8);
        #2 reset = 1'b1;
        #1;
        chk("mid.state_async", int'(state_o), 0);
        chk("mid.count_async", int'(count_o), 0);
        chk("mid.done_async", int'(done_o), 0);
        @(posedge clock); @(posedge clock); #1;
        reset = 1'b0;
        arm_i = 1; step(); arm_i = 0;
        for (int k = 0; k < 3; k++) begin
            data_i = 8'(8'hC0 + k); trigger_i = (k == 0); stop_i = (k == 2);
            step();
        end
        trigger_i = 0; stop_i = 0;
        chk("post.count", int'(count_o), 3);
        chk("post.state", int'(state_o), 3);
        read_i = 1; step(); read_i = 0;
        chk("post.rv", int'(rvalid_o), 1);
        chk("post.rd0", int'(rdata_o), 8'hC0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tdc_trace_capture.md
# tdc_trace_capture

Acquisition buffer directly downstream of the TDC bank. It records the per-cycle TDC bank output (summed delay-line value) into an on-chip buffer. Recording starts when the crypto core raises its start trigger and ends on a stop pulse or when the buffer is full. The captured trace is then drained word by word through a pop interface, which the AXI4-Lite register wrapper exposes to the host.

## Interface
Parameters:
- DATA_WIDTH, 8, width of one TDC bank sample
- DEPTH, 1024, trace buffer length in samples; power of two, ≥ 4
- ADDR_WIDTH, $clog2(DEPTH), buffer address width (derived, not overridden)

Ports:
- clock  in  1  single clock domain; all logic samples on its rising edge
- reset  in  1  asynchronous, active-high reset
- data_i  in  DATA_WIDTH  TDC bank sample, valid every cycle
- arm_i  in  1  single-cycle pulse that clears the buffer and arms capture
- trigger_i  in  1  capture start, level or pulse; only the first high cycle in ARMED counts
- stop_i  in  1  single-cycle pulse that ends capture early
- read_i  in  1  pop request, one word per high cycle
- rdata_o  out  DATA_WIDTH  popped sample
- rvalid_o  out  1  one-cycle strobe that qualifies rdata_o
- count_o  out  ADDR_WIDTH+1  number of samples captured in the current trace
- empty_o  out  1  DONE state and all captured samples popped
- done_o  out  1  high while in DONE
- state_o  out  2  IDLE=0, ARMED=1, CAPTURE=2, DONE=3

## Operation
State machine:
- IDLE: no writes or pops. arm_i → ARMED.
- ARMED: entry clears the write pointer, read pointer and count_o to 0.
  - trigger_i → CAPTURE. The data_i value on the trigger cycle is written to address 0 and count_o becomes 1.
  - arm_i → re-enter ARMED.
- CAPTURE: writes data_i at address count_o on every cycle and increments count_o.
  - stop_i → DONE. The sample present on the stop cycle is written.
  - Leaves for DONE on the cycle count_o reaches DEPTH. No write occurs at or beyond DEPTH; the pointer never wraps.
  - arm_i, trigger_i and read_i are ignored.
- DONE: read_i with read pointer < count_o → RAM read at the read pointer, then the pointer increments.
  - read_i when empty → ignored: rvalid_o stays 0 and rdata_o holds its value.
  - arm_i → ARMED and discards the trace. arm_i and read_i in the same cycle: arm wins and the read is dropped.

Other rules:
- In IDLE, arm_i and trigger_i in the same cycle → ARMED only. That trigger is not honoured, and trigger_i must fall and rise again.
- Arithmetic: count_o saturates at DEPTH (needs ADDR_WIDTH+1 bits). The read pointer is also ADDR_WIDTH+1 bits. empty_o = done_o && (read pointer == count_o).
- Reset mid-operation: returns to IDLE immediately. Buffer contents are not cleared and are unreadable until the next capture.

## Timing
- Reset values: state_o=0, rdata_o=0, rvalid_o=0, count_o=0, empty_o=0, done_o=0.
- Capture latency: trigger_i high in ARMED at cycle n → state_o=CAPTURE and count_o=1 at n+1.
- Stop: stop_i at cycle m → done_o=1 at m+1, and count_o includes the sample from cycle m.
- Full: DONE is reached at cycle t+DEPTH for a trigger at cycle t.
- Pop latency: read_i at cycle n → rdata_o updated and rvalid_o high at n+1, driven straight from the synchronous RAM output register. Back-to-back pops are sustained at one word per cycle.
- empty_o updates on the cycle after the final accepted pop.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Package tdc_trace_pkg holds:
  - the state enum (IDLE, ARMED, CAPTURE, DONE, 2 bits), shared with the register wrapper for status decoding;
  - the default DATA_WIDTH and DEPTH constants.
- Sub-module tdc_trace_ram: simple dual-port RAM (one write port, one registered read port), DEPTH × DATA_WIDTH, inferable as BRAM. No reset on the array.
- Top level: state machine, pointers and output registers.

## Test plan
- Reset then idle: hold reset 5 cycles, then release → all outputs 0. Pulses of read_i and trigger_i in IDLE → no change.
- Full capture, DEPTH=16: arm, hold data_i = cycle index starting at 0xA0, trigger at cycle t → done_o at t+16 and count_o=16. 16 back-to-back pops → rvalid_o high 16 cycles with data 0xA0..0xAF, then empty_o=1.
- Early stop: trigger, then stop_i on the 5th capture cycle → count_o=5. Pops return the 5 samples in order. A 6th pop gives rvalid_o=0 with rdata_o unchanged.
- Simultaneous events:
  - arm_i+trigger_i together in IDLE → ARMED, no capture.
  - arm_i+read_i together in DONE → ARMED with count_o=0 and no rvalid_o.
- Re-arm and overwrite: capture 0x11 pattern, pop 2 words, arm, capture 0x22 pattern for 4 samples → pops return only 0x22 data and count_o=4.
- Reset mid-capture: assert reset 8 cycles into a capture → state_o=0 and count_o=0 asynchronously. A later arm/trigger captures normally from address 0.
